dram_axi_burst_writer: RTL

DRAM_AXI_BURST_WRITER -- requirements
Module: dram_axi_burst_writer

---
 rtl/dram_axi_pkg.sv | 17 +
 rtl/dram_burst_len_calc.sv | 46 ++++
 rtl/dram_axi_burst_writer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/dram_axi_pkg.sv
// Shared types and constants for the DRAM AXI burst writer.
// Optional 4 KiB burst splitting is enabled by defining DRAM_WR_4K_SPLIT_EN.
package dram_axi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        DATA  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } wr_state_e;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    localparam int unsigned BOUNDARY_4K = 4096;

endpackage

// File: rtl/dram_burst_len_calc.sv
// Combinational burst sizing: min(remaining, 2**BURST_LEN_WIDTH), additionally
// clipped at the next 4 KiB boundary when DRAM_WR_4K_SPLIT_EN is defined.
module dram_burst_len_calc
    import dram_axi_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int BURST_LEN_WIDTH = 8,
    parameter int STRB_WIDTH      = 64
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [15:0]           remaining,
    output logic [16:0]           beats
);

`ifdef DRAM_WR_4K_SPLIT_EN
    localparam bit SPLIT_4K = 1'b1;
`else
    localparam bit SPLIT_4K = 1'b0;
`endif

    localparam int              SIZE_LOG2  = $clog2(STRB_WIDTH);
    localparam logic [16:0]     MAX_BEATS  = 17'(1 << BURST_LEN_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] BOUND     = ADDR_WIDTH'(BOUNDARY_4K);
    localparam logic [ADDR_WIDTH-1:0] BOUND_MSK = ADDR_WIDTH'(BOUNDARY_4K - 1);

    logic [ADDR_WIDTH-1:0] room_bytes_s;
    logic [ADDR_WIDTH-1:0] room_beats_s;
    logic [16:0]           capped_s;

    // Beats that fit before the next 4 KiB boundary and the awlen-limited size.
    always_comb begin
        room_bytes_s = BOUND - (addr & BOUND_MSK);
        room_beats_s = room_bytes_s >> SIZE_LOG2;
        if ({1'b0, remaining} > MAX_BEATS) begin
            capped_s = MAX_BEATS;
        end else begin
            capped_s = {1'b0, remaining};
        end
        if (SPLIT_4K && (room_beats_s < ADDR_WIDTH'(capped_s))) begin
            beats = 17'(room_beats_s);
        end else begin
            beats = capped_s;
        end
    end

endmodule

// File: rtl/dram_axi_burst_writer.sv
// Splits a beat-count write request into AXI write bursts, streams the data
// through and reports completion after all B responses (DRAM_WR_4K_SPLIT_EN adds 4 KiB splitting).
module dram_axi_burst_writer
    import dram_axi_pkg::*;
#(
    parameter int DRAM_DATA_WIDTH = 512,
    parameter int ADDR_WIDTH      = 32,
    parameter int BURST_LEN_WIDTH = 8,
    parameter int ID_WIDTH        = 8,
    parameter int STRB_WIDTH      = DRAM_DATA_WIDTH / 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [ADDR_WIDTH-1:0]      req_addr,
    input  logic [15:0]                req_beats,
    input  logic [ID_WIDTH-1:0]        req_id,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [DRAM_DATA_WIDTH-1:0] wr_data,
    input  logic [STRB_WIDTH-1:0]      wr_strb,
    output logic                       done_valid,
    output logic                       done_err,
    output logic                       ddr_awvalid,
    input  logic                       ddr_awready,
    output logic [ADDR_WIDTH-1:0]      ddr_awaddr,
    output logic [BURST_LEN_WIDTH-1:0] ddr_awlen,
    output logic [2:0]                 ddr_awsize,
    output logic [ID_WIDTH-1:0]        ddr_awid,
    output logic                       ddr_wvalid,
    input  logic                       ddr_wready,
    output logic [DRAM_DATA_WIDTH-1:0] ddr_wdata,
    output logic [STRB_WIDTH-1:0]      ddr_wstrb,
    output logic                       ddr_wlast,
    input  logic                       ddr_bvalid,
    output logic                       ddr_bready,
    input  logic [ID_WIDTH-1:0]        ddr_bid,
    input  logic [1:0]                 ddr_bresp
);

    localparam int SIZE_LOG2 = $clog2(STRB_WIDTH);
    localparam int OUT_W     = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(STRB_WIDTH - 1);

    wr_state_e                  state_r;
    logic                       req_ready_r;
    logic                       awvalid_r;
    logic [ADDR_WIDTH-1:0]      awaddr_r;
    logic [BURST_LEN_WIDTH-1:0] awlen_r;
    logic [ID_WIDTH-1:0]        awid_r;
    logic                       done_valid_r;
    logic                       err_r;
    logic                       bready_r;
    logic [ADDR_WIDTH-1:0]      addr_r;
    logic [15:0]                remaining_r;
    logic [16:0]                beat_cnt_r;
    logic [16:0]                burst_beats_r;
    logic [ID_WIDTH-1:0]        id_r;
    logic [OUT_W-1:0]           outstanding_r;

    logic [16:0] beats_s;
    logic        aw_fire_s;
    logic        b_fire_s;
    logic        in_data_s;
    logic        bid_unused_s;

    dram_burst_len_calc #(
        .ADDR_WIDTH      (ADDR_WIDTH),
        .BURST_LEN_WIDTH (BURST_LEN_WIDTH),
        .STRB_WIDTH      (STRB_WIDTH)
    ) u_len_calc (
        .addr      (addr_r),
        .remaining (remaining_r),
        .beats     (beats_s)
    );

    // B responses with nothing outstanding are stale (e.g. after a reset) and dropped.
    assign aw_fire_s    = awvalid_r & ddr_awready;
    assign b_fire_s     = ddr_bvalid & bready_r & (outstanding_r != OUT_W'(0));
    assign in_data_s    = (state_r == DATA);
    assign bid_unused_s = ^ddr_bid;

    assign req_ready   = req_ready_r;
    assign done_valid  = done_valid_r;
    assign done_err    = err_r;
    assign ddr_awvalid = awvalid_r;
    assign ddr_awaddr  = awaddr_r;
    assign ddr_awlen   = awlen_r;
    assign ddr_awsize  = 3'(SIZE_LOG2);
    assign ddr_awid    = awid_r;
    assign ddr_wvalid  = in_data_s & wr_valid;
    assign wr_ready    = in_data_s & ddr_wready;
    assign ddr_wdata   = wr_data;
    assign ddr_wstrb   = wr_strb;
    assign ddr_wlast   = in_data_s & (beat_cnt_r == 17'd1);
    assign ddr_bready  = bready_r;

    // B channel is always accepted once out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            bready_r <= 1'b0;
        end else begin
            bready_r <= 1'b1;
        end
    end

    // Count of bursts whose address was sent but whose B has not returned.
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding_r <= OUT_W'(0);
        end else begin
            case ({aw_fire_s, b_fire_s})
                2'b10:   outstanding_r <= outstanding_r + OUT_W'(1);
                2'b01:   outstanding_r <= outstanding_r - OUT_W'(1);
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

    // Request FSM with registered handshake and address-channel outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            req_ready_r   <= 1'b0;
            awvalid_r     <= 1'b0;
            awaddr_r      <= '0;
            awlen_r       <= '0;
            awid_r        <= '0;
            done_valid_r  <= 1'b0;
            err_r         <= 1'b0;
            addr_r        <= '0;
            remaining_r   <= 16'd0;
            beat_cnt_r    <= 17'd0;
            burst_beats_r <= 17'd0;
            id_r          <= '0;
        end else begin
            // Error accumulation first so that acceptance of a new request clears it.
            if (b_fire_s && (ddr_bresp != AXI_RESP_OKAY)) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
            case (state_r)
                IDLE: begin
                    done_valid_r <= 1'b0;
                    if (req_ready_r && req_valid) begin
                        req_ready_r <= 1'b0;
                        err_r       <= 1'b0;
                        addr_r      <= req_addr & ALIGN_MASK;
                        remaining_r <= req_beats;
                        id_r        <= req_id;
                        if (req_beats == 16'd0) begin
                            state_r      <= DONE;
                            done_valid_r <= 1'b1;
                        end else begin
                            state_r <= ADDR;
                        end
                    end else begin
                        req_ready_r <= 1'b1;
                    end
                end
                ADDR: begin
                    if (awvalid_r && ddr_awready) begin
                        awvalid_r   <= 1'b0;
                        beat_cnt_r  <= burst_beats_r;
                        addr_r      <= addr_r + (ADDR_WIDTH'(burst_beats_r) << SIZE_LOG2);
                        remaining_r <= remaining_r - 16'(burst_beats_r);
                        state_r     <= DATA;
                    end else if (!awvalid_r && (outstanding_r < OUT_W'(MAX_OUTSTANDING))) begin
                        awvalid_r     <= 1'b1;
                        awaddr_r      <= addr_r;
                        awlen_r       <= BURST_LEN_WIDTH'(beats_s - 17'd1);
                        awid_r        <= id_r;
                        burst_beats_r <= beats_s;
                    end else begin
                        state_r <= ADDR;
                    end
                end
                DATA: begin
                    if (wr_valid && ddr_wready) begin
                        beat_cnt_r <= beat_cnt_r - 17'd1;
                        if (beat_cnt_r == 17'd1) begin
                            state_r <= (remaining_r != 16'd0) ? ADDR : DRAIN;
                        end else begin
                            state_r <= DATA;
                        end
                    end else begin
                        state_r <= DATA;
                    end
                end
                DRAIN: begin
                    if (outstanding_r == OUT_W'(0)) begin
                        state_r      <= DONE;
                        done_valid_r <= 1'b1;
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                DONE: begin
                    done_valid_r <= 1'b0;
                    req_ready_r  <= 1'b1;
                    state_r      <= IDLE;
                end
                default: begin
                    state_r      <= IDLE;
                    req_ready_r  <= 1'b0;
                    awvalid_r    <= 1'b0;
                    done_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule
